zube_fifo: RTL and testbench



---
 rtl/zube_fifo_pkg.sv | 57 +++++
 rtl/zube_fifo_sync_fifo.sv | 71 +++++++
 rtl/zube_fifo.sv | 201 ++++++++++++++++++++
 tb/tb_zube_fifo.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zube_fifo_pkg.sv
// Shared definitions for the Z80/SoC mailbox: Wishbone register offsets, status bit positions,
// the register-select decode and the Z80-side synchroniser state.
package zube_fifo_pkg;

   localparam logic [31:0] REG_BASE     = 32'h00;
   localparam logic [31:0] REG_DATA     = 32'h04;
   localparam logic [31:0] REG_LEVEL    = 32'h08;
   localparam logic [31:0] REG_IRQ_EN   = 32'h0C;
   localparam logic [31:0] REG_IRQ_STAT = 32'h10;

   localparam int IRQ_RX_NOT_EMPTY = 0;
   localparam int IRQ_TX_EMPTY     = 1;
   localparam int IRQ_RX_OVERFLOW  = 2;
   localparam int IRQ_TX_OVERFLOW  = 3;
   localparam int IRQ_Z80_UNDERFLOW = 4;

   localparam int Z80_ST_TX_NOT_EMPTY = 0;
   localparam int Z80_ST_RX_NOT_FULL  = 1;

   localparam logic [7:0] UNDERFLOW_BYTE = 8'hFF;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_BASE,
      SEL_DATA,
      SEL_LEVEL,
      SEL_IRQ_EN,
      SEL_IRQ_STAT
   } reg_sel_e;

   // Strobes are active low, so their synchroniser stages reset to 1 (idle).
   typedef struct packed {
      logic [1:0] wr_b;
      logic [1:0] rd_b;
      logic       wr_prev_b;
      logic       rd_prev_b;
      logic [7:0] addr_meta;
      logic [7:0] addr;
      logic [7:0] din;
   } z80_sync_t;

   localparam z80_sync_t SYNC_RESET = '{wr_b: 2'b11, rd_b: 2'b11, wr_prev_b: 1'b1,
                                        rd_prev_b: 1'b1, addr_meta: 8'h00, addr: 8'h00,
                                        din: 8'h00};

   function automatic reg_sel_e decode_reg(input logic [31:0] off);
      case (off)
         REG_BASE:     return SEL_BASE;
         REG_DATA:     return SEL_DATA;
         REG_LEVEL:    return SEL_LEVEL;
         REG_IRQ_EN:   return SEL_IRQ_EN;
         REG_IRQ_STAT: return SEL_IRQ_STAT;
         default:      return SEL_NONE;
      endcase
   endfunction

endpackage

// File: rtl/zube_fifo_sync_fifo.sv
// Generic byte FIFO with combinational head, 1-cycle push/pop to count/flags.
// Push when full is dropped (overflow_pulse) unless a pop lands the same cycle; pop when empty is ignored.
module sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow_pulse
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [WIDTH-1:0]      mem_d [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  do_push, do_pop;

   assign empty          = (count_q == '0);
   assign full           = (count_q == FULL_COUNT);
   assign count          = count_q;
   assign rdata          = mem_q[rd_ptr_q];
   assign do_pop         = pop & ~empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_push        = push & (~full | do_pop);
   assign overflow_pulse = push & ~do_push;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/zube_fifo.sv
// Z80<->SoC mailbox: RX (Z80->SoC) and TX (SoC->Z80) byte FIFOs, level/status regs, maskable irq.
// Wishbone ack 1 cycle after request, never stalls; Z80 side acts 2-3 clk after strobe edges.
module zube_fifo #(
   parameter logic [31:0] BASE_ADDRESS   = 32'h3000_0000,
   parameter int          DEPTH_LOG2     = 4,
   parameter logic [7:0]  Z80_BASE_RESET = 8'h80
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        z80_write_strobe_b,
   input  logic        z80_read_strobe_b,
   input  logic [7:0]  z80_address_bus,
   input  logic [7:0]  z80_data_bus_in,
   output logic [7:0]  z80_data_bus_out,
   output logic        z80_bus_dir,
   input  logic        wb_cyc_in,
   input  logic        wb_stb_in,
   input  logic        wb_we_in,
   input  logic [31:0] wb_addr_in,
   input  logic [31:0] wb_data_in,
   output logic        wb_ack_out,
   output logic        wb_stall_out,
   output logic [31:0] wb_data_out,
   output logic        irq_out
);
   import zube_fifo_pkg::*;

   z80_sync_t           sync_q, sync_d;
   logic [7:0]          base_q, base_d, dout_q, dout_d;
   logic                dir_q, dir_d, pop_pend_q, pop_pend_d;
   logic [4:0]          irq_en_q, irq_en_d;
   logic                rxo_q, rxo_d, txo_q, txo_d, uf_q, uf_d;
   logic                irq_q, irq_d, ack_q, ack_d;
   logic [31:0]         wb_dat_q, wb_dat_d;

   logic                rx_push, rx_pop, tx_push, tx_pop;
   logic [7:0]          rx_head, tx_head;
   logic                rx_full, rx_empty, tx_full, tx_empty, rx_ovf, tx_ovf;
   logic [DEPTH_LOG2:0] rx_count, tx_count;
   logic                wr_rise, rd_fall, rd_rise, hit_data, hit_stat, uf_set;
   logic [31:0]         wb_off;
   reg_sel_e            wb_sel;
   logic                wb_req;
   logic [4:0]          irq_status, w1c;
   logic                unused_bits;

   assign unused_bits = ^{wb_data_in[31:8], tx_full};

   assign wr_rise  = sync_q.wr_b[1] & ~sync_q.wr_prev_b;
   assign rd_fall  = ~sync_q.rd_b[1] & sync_q.rd_prev_b;
   assign rd_rise  = sync_q.rd_b[1] & ~sync_q.rd_prev_b;
   assign hit_data = (sync_q.addr == base_q);
   assign hit_stat = (sync_q.addr == 8'(base_q + 8'd1));
   assign rx_push  = wr_rise & hit_data;

   always_comb begin
      sync_d           = sync_q;
      sync_d.wr_b      = {sync_q.wr_b[0], z80_write_strobe_b};
      sync_d.rd_b      = {sync_q.rd_b[0], z80_read_strobe_b};
      sync_d.wr_prev_b = sync_q.wr_b[1];
      sync_d.rd_prev_b = sync_q.rd_b[1];
      sync_d.addr_meta = z80_address_bus;
      sync_d.addr      = sync_q.addr_meta;
      sync_d.din       = z80_data_bus_in;
   end

   // The TX pop is deferred to strobe release so the byte stays on the bus for the whole read.
   always_comb begin
      dout_d     = dout_q;
      dir_d      = dir_q;
      pop_pend_d = pop_pend_q;
      tx_pop     = 1'b0;
      uf_set     = 1'b0;
      if (rd_fall && hit_data) begin
         dir_d = 1'b1;
         if (tx_empty) begin
            dout_d = UNDERFLOW_BYTE;
            uf_set = 1'b1;
         end else begin
            dout_d     = tx_head;
            pop_pend_d = 1'b1;
         end
      end else if (rd_fall && hit_stat) begin
         dir_d                       = 1'b1;
         dout_d                      = '0;
         dout_d[Z80_ST_TX_NOT_EMPTY] = ~tx_empty;
         dout_d[Z80_ST_RX_NOT_FULL]  = ~rx_full;
      end
      if (rd_rise) begin
         dir_d      = 1'b0;
         tx_pop     = pop_pend_q;
         pop_pend_d = 1'b0;
      end
   end

   assign wb_off = wb_addr_in - BASE_ADDRESS;
   assign wb_sel = decode_reg(wb_off);
   assign wb_req = wb_cyc_in & wb_stb_in & (wb_sel != SEL_NONE);

   always_comb begin
      irq_status                    = '0;
      irq_status[IRQ_RX_NOT_EMPTY]  = ~rx_empty;
      irq_status[IRQ_TX_EMPTY]      = tx_empty;
      irq_status[IRQ_RX_OVERFLOW]   = rxo_q;
      irq_status[IRQ_TX_OVERFLOW]   = txo_q;
      irq_status[IRQ_Z80_UNDERFLOW] = uf_q;
   end

   always_comb begin
      base_d   = base_q;
      irq_en_d = irq_en_q;
      wb_dat_d = '0;
      ack_d    = wb_req;
      tx_push  = 1'b0;
      rx_pop   = 1'b0;
      w1c      = '0;
      if (wb_req) begin
         case (wb_sel)
            SEL_BASE: begin
               if (wb_we_in) base_d = wb_data_in[7:0];
               else          wb_dat_d = {24'b0, base_q};
            end
            SEL_DATA: begin
               if (wb_we_in) begin
                  tx_push = 1'b1;
               end else begin
                  rx_pop   = 1'b1;
                  wb_dat_d = rx_empty ? 32'h0 : {23'b0, 1'b1, rx_head};
               end
            end
            SEL_LEVEL: begin
               if (!wb_we_in) wb_dat_d = {7'b0, 9'(tx_count), 7'b0, 9'(rx_count)};
            end
            SEL_IRQ_EN: begin
               if (wb_we_in) irq_en_d = wb_data_in[4:0];
               else          wb_dat_d = {27'b0, irq_en_q};
            end
            SEL_IRQ_STAT: begin
               if (wb_we_in) w1c = wb_data_in[4:0];
               else          wb_dat_d = {27'b0, irq_status};
            end
            default: ;
         endcase
      end
      // A fresh event outranks a same-cycle W1C so it is never lost.
      rxo_d = (rxo_q & ~w1c[IRQ_RX_OVERFLOW]) | rx_ovf;
      txo_d = (txo_q & ~w1c[IRQ_TX_OVERFLOW]) | tx_ovf;
      uf_d  = (uf_q & ~w1c[IRQ_Z80_UNDERFLOW]) | uf_set;
      irq_d = |(irq_status & irq_en_q);
   end

   sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
      .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .wdata(sync_q.din),
      .rdata(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count),
      .overflow_pulse(rx_ovf)
   );

   sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
      .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .wdata(wb_data_in[7:0]),
      .rdata(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count),
      .overflow_pulse(tx_ovf)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q     <= SYNC_RESET;
         base_q     <= Z80_BASE_RESET;
         dout_q     <= '0;
         dir_q      <= 1'b0;
         pop_pend_q <= 1'b0;
         irq_en_q   <= '0;
         rxo_q      <= 1'b0;
         txo_q      <= 1'b0;
         uf_q       <= 1'b0;
         irq_q      <= 1'b0;
         ack_q      <= 1'b0;
         wb_dat_q   <= '0;
      end else begin
         sync_q     <= sync_d;
         base_q     <= base_d;
         dout_q     <= dout_d;
         dir_q      <= dir_d;
         pop_pend_q <= pop_pend_d;
         irq_en_q   <= irq_en_d;
         rxo_q      <= rxo_d;
         txo_q      <= txo_d;
         uf_q       <= uf_d;
         irq_q      <= irq_d;
         ack_q      <= ack_d;
         wb_dat_q   <= wb_dat_d;
      end
   end

   assign z80_data_bus_out = dout_q;
   assign z80_bus_dir      = dir_q;
   assign wb_ack_out       = ack_q;
   assign wb_stall_out     = 1'b0;
   assign wb_data_out      = wb_dat_q;
   assign irq_out          = irq_q;

endmodule

// File: tb/tb_zube_fifo.sv
// Bench for zube_fifo: directed scenarios then random traffic against a queue-based mailbox model;
// expected responses are queued at issue time and checked by monitors on ack / bus-drive.
module tb_zube_fifo;
   import zube_fifo_pkg::*;

   localparam logic [31:0] BASE  = 32'h3000_0000;
   localparam int          DL2   = 4;
   localparam int          DEPTH = 1 << DL2;

   logic        clk = 1'b0;
   logic        reset;
   logic        z80_write_strobe_b, z80_read_strobe_b;
   logic [7:0]  z80_address_bus, z80_data_bus_in, z80_data_bus_out;
   logic        z80_bus_dir;
   logic        wb_cyc_in, wb_stb_in, wb_we_in;
   logic [31:0] wb_addr_in, wb_data_in, wb_data_out;
   logic        wb_ack_out, wb_stall_out, irq_out;

   always #5 clk = ~clk;

   zube_fifo #(.BASE_ADDRESS(BASE), .DEPTH_LOG2(DL2), .Z80_BASE_RESET(8'h80)) dut (
      .clk(clk), .reset(reset),
      .z80_write_strobe_b(z80_write_strobe_b), .z80_read_strobe_b(z80_read_strobe_b),
      .z80_address_bus(z80_address_bus), .z80_data_bus_in(z80_data_bus_in),
      .z80_data_bus_out(z80_data_bus_out), .z80_bus_dir(z80_bus_dir),
      .wb_cyc_in(wb_cyc_in), .wb_stb_in(wb_stb_in), .wb_we_in(wb_we_in),
      .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in), .wb_ack_out(wb_ack_out),
      .wb_stall_out(wb_stall_out), .wb_data_out(wb_data_out), .irq_out(irq_out)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference model: the two FIFOs as queues plus the software-visible registers.
   logic [7:0] rx_m[$];
   logic [7:0] tx_m[$];
   logic [7:0] base_m;
   logic [4:0] en_m;
   logic       rxo_m, txo_m, uf_m;

   function automatic logic [4:0] status_m();
      return {uf_m, txo_m, rxo_m, tx_m.size() == 0, rx_m.size() != 0};
   endfunction

   typedef struct { logic chk; logic [31:0] dat; } wb_exp_t;
   wb_exp_t    wb_q[$];
   logic [7:0] z80_q[$];

   initial begin : wb_monitor
      wb_exp_t e;
      forever begin
         @(negedge clk);
         if (wb_ack_out === 1'b1) begin
            if (wb_q.size() == 0) begin
               check("wb_unexpected_ack", 32'(wb_ack_out), 32'd0);
            end else begin
               e = wb_q.pop_front();
               if (e.chk) check("wb_rdata", wb_data_out, e.dat);
            end
         end
      end
   end

   initial begin : z80_monitor
      logic dir_prev;
      dir_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (z80_bus_dir === 1'b1 && dir_prev === 1'b0) begin
            if (z80_q.size() == 0) check("z80_unexpected_drive", 32'(z80_bus_dir), 32'd0);
            else                   check("z80_rdata", 32'(z80_data_bus_out), 32'(z80_q.pop_front()));
         end
         dir_prev = z80_bus_dir;
      end
   end

   initial begin : watchdog
      #600_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   logic irq_at_ack, irq_after_ack;
   int   irq_rise_cyc;

   task automatic wb_xfer(input logic we, input logic [31:0] off, input logic [31:0] wd,
                          input logic chk, input logic [31:0] exp, input logic mapped);
      wb_exp_t e;
      e.chk = chk;
      e.dat = exp;
      if (mapped) wb_q.push_back(e);
      @(negedge clk);
      wb_cyc_in = 1'b1; wb_stb_in = 1'b1; wb_we_in = we;
      wb_addr_in = BASE + off; wb_data_in = wd;
      @(negedge clk);
      wb_cyc_in = 1'b0; wb_stb_in = 1'b0; wb_we_in = 1'b0;
      check("wb_ack_timing", 32'(wb_ack_out), 32'(mapped));
      irq_at_ack = irq_out;
      @(negedge clk);
      irq_after_ack = irq_out;
      @(negedge clk);
   endtask

   task automatic wb_rd_data();
      logic [31:0] ex;
      ex = 32'h0;
      if (rx_m.size() != 0) ex = {23'b0, 1'b1, rx_m.pop_front()};
      wb_xfer(1'b0, REG_DATA, 32'h0, 1'b1, ex, 1'b1);
   endtask

   task automatic wb_wr_data(input logic [7:0] b);
      logic [31:0] wd;
      wd      = $urandom;
      wd[7:0] = b;
      if (tx_m.size() == DEPTH) txo_m = 1'b1;
      else                      tx_m.push_back(b);
      wb_xfer(1'b1, REG_DATA, wd, 1'b0, 32'h0, 1'b1);
   endtask

   task automatic wb_rd_level();
      wb_xfer(1'b0, REG_LEVEL, 32'h0, 1'b1,
              {7'b0, 9'(tx_m.size()), 7'b0, 9'(rx_m.size())}, 1'b1);
   endtask

   task automatic wb_rd_status();
      wb_xfer(1'b0, REG_IRQ_STAT, 32'h0, 1'b1, {27'b0, status_m()}, 1'b1);
   endtask

   task automatic wb_rd_reg(input logic [31:0] off);
      logic [31:0] ex;
      ex = (off == REG_BASE) ? {24'b0, base_m} : {27'b0, en_m};
      wb_xfer(1'b0, off, 32'h0, 1'b1, ex, 1'b1);
   endtask

   task automatic wb_wr_reg(input logic [31:0] off, input logic [31:0] val);
      if (off == REG_BASE)   base_m = val[7:0];
      if (off == REG_IRQ_EN) en_m   = val[4:0];
      if (off == REG_IRQ_STAT) begin
         if (val[2]) rxo_m = 1'b0;
         if (val[3]) txo_m = 1'b0;
         if (val[4]) uf_m  = 1'b0;
      end
      wb_xfer(1'b1, off, val, 1'b0, 32'h0, 1'b1);
   endtask

   task automatic z80_wr(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      z80_address_bus = a; z80_data_bus_in = d;
      @(negedge clk);
      z80_write_strobe_b = 1'b0;
      repeat (4) @(negedge clk);
      z80_write_strobe_b = 1'b1;
      if (a == base_m) begin
         if (rx_m.size() == DEPTH) rxo_m = 1'b1;
         else                      rx_m.push_back(d);
      end
      irq_rise_cyc = -1;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (irq_out === 1'b1 && irq_rise_cyc < 0) irq_rise_cyc = i;
      end
   endtask

   task automatic z80_rd(input logic [7:0] a);
      logic hit;
      hit = (a == base_m) || (a == 8'(base_m + 8'd1));
      @(negedge clk);
      z80_address_bus = a;
      if (a == base_m) begin
         if (tx_m.size() == 0) begin
            z80_q.push_back(UNDERFLOW_BYTE);
            uf_m = 1'b1;
         end else begin
            z80_q.push_back(tx_m.pop_front());
         end
      end else if (hit) begin
         z80_q.push_back({6'b0, rx_m.size() != DEPTH, tx_m.size() != 0});
      end
      @(negedge clk);
      z80_read_strobe_b = 1'b0;
      repeat (5) @(negedge clk);
      check("z80_dir_in_strobe", 32'(z80_bus_dir), 32'(hit));
      z80_read_strobe_b = 1'b1;
      repeat (6) @(negedge clk);
      check("z80_dir_after_strobe", 32'(z80_bus_dir), 32'd0);
   endtask

   task automatic check_irq();
      check("irq_out", 32'(irq_out), 32'(|(status_m() & en_m)));
   endtask

   initial begin : stimulus
      logic [7:0] a;
      int unsigned op;
      reset = 1'b1;
      z80_write_strobe_b = 1'b1; z80_read_strobe_b = 1'b1;
      z80_address_bus = 8'h00; z80_data_bus_in = 8'h00;
      wb_cyc_in = 1'b0; wb_stb_in = 1'b0; wb_we_in = 1'b0;
      wb_addr_in = 32'h0; wb_data_in = 32'h0;
      base_m = 8'h80; en_m = 5'h0; rxo_m = 1'b0; txo_m = 1'b0; uf_m = 1'b0;
      irq_at_ack = 1'b0; irq_after_ack = 1'b0; irq_rise_cyc = -1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_z80_dout", 32'(z80_data_bus_out), 32'd0);
      check("rst_z80_dir", 32'(z80_bus_dir), 32'd0);
      check("rst_wb_ack", 32'(wb_ack_out), 32'd0);
      check("rst_wb_data", wb_data_out, 32'd0);
      check("rst_irq", 32'(irq_out), 32'd0);
      check("rst_wb_stall", 32'(wb_stall_out), 32'd0);
      wb_rd_level();
      wb_rd_reg(REG_BASE);
      wb_rd_status();

      // Z80 -> SoC bytes, including the read past empty.
      z80_wr(8'h80, 8'h11);
      z80_wr(8'h80, 8'h22);
      z80_wr(8'h80, 8'h33);
      wb_rd_level();
      repeat (4) wb_rd_data();

      // TX fill to 16 plus one dropped byte, then drain from the Z80 side.
      for (int i = 0; i <= DEPTH; i++) wb_wr_data(8'(i));
      wb_rd_level();
      wb_rd_status();
      for (int i = 0; i < DEPTH; i++) z80_rd(8'h80);

      // Underflow sticky and its W1C.
      z80_rd(8'h80);
      wb_rd_status();
      wb_wr_reg(REG_IRQ_STAT, 32'h10);
      wb_rd_status();

      // Interrupt timing around a single RX byte.
      wb_wr_reg(REG_IRQ_STAT, 32'h1C);
      wb_wr_reg(REG_IRQ_EN, 32'h01);
      check_irq();
      z80_wr(8'h80, 8'hA5);
      check("irq_rise_latency", 32'((irq_rise_cyc >= 1) && (irq_rise_cyc <= 4)), 32'd1);
      wb_rd_data();
      check("irq_at_ack", 32'(irq_at_ack), 32'd1);
      check("irq_after_ack", 32'(irq_after_ack), 32'd0);

      // Relocated Z80 base and the status port.
      wb_wr_reg(REG_BASE, 32'h40);
      wb_rd_reg(REG_BASE);
      z80_wr(8'h80, 8'h77);
      z80_wr(8'h40, 8'h5A);
      wb_wr_data(8'h99);
      wb_rd_level();
      z80_rd(8'h41);
      check_irq();

      // Unmapped Wishbone address gets no ack.
      wb_xfer(1'b0, 32'h14, 32'h0, 1'b0, 32'h0, 1'b0);

      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 3))
            0, 1:    a = base_m;
            2:       a = 8'(base_m + 8'd1);
            default: a = 8'($urandom);
         endcase
         op = $urandom_range(0, 8);
         case (op)
            0, 1:    z80_wr(a, 8'($urandom));
            2, 3:    z80_rd(a);
            4:       wb_wr_data(8'($urandom));
            5:       wb_rd_data();
            6:       wb_rd_level();
            7:       wb_rd_status();
            default: wb_wr_reg(($urandom_range(0, 1) == 0) ? REG_IRQ_EN : REG_IRQ_STAT,
                               32'($urandom));
         endcase
         check_irq();
      end

      // Reset in the middle of a Z80 read with both FIFOs holding 5 bytes.
      while (rx_m.size() != 0) wb_rd_data();
      while (tx_m.size() != 0) z80_rd(base_m);
      for (int i = 0; i < 5; i++) z80_wr(base_m, 8'(8'hC0 + i));
      for (int i = 0; i < 5; i++) wb_wr_data(8'(8'hD0 + i));
      wb_wr_reg(REG_IRQ_EN, 32'h01);
      wb_rd_level();
      @(negedge clk);
      z80_address_bus = base_m;
      z80_q.push_back(tx_m[0]);
      z80_read_strobe_b = 1'b0;
      repeat (5) @(negedge clk);
      check("pre_rst_dir", 32'(z80_bus_dir), 32'd1);
      check("pre_rst_irq", 32'(irq_out), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_dir", 32'(z80_bus_dir), 32'd0);
      check("mid_rst_dout", 32'(z80_data_bus_out), 32'd0);
      check("mid_rst_irq", 32'(irq_out), 32'd0);
      check("mid_rst_ack", 32'(wb_ack_out), 32'd0);
      z80_read_strobe_b = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      rx_m.delete(); tx_m.delete();
      base_m = 8'h80; en_m = 5'h0; rxo_m = 1'b0; txo_m = 1'b0; uf_m = 1'b0;
      repeat (4) @(negedge clk);
      wb_rd_level();
      wb_rd_reg(REG_BASE);
      wb_rd_reg(REG_IRQ_EN);
      wb_rd_status();
      check_irq();

      repeat (10) @(negedge clk);
      check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
      check("z80_queue_drained", 32'(z80_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
